if_fetch_queue: RTL

Instruction-fetch buffer between the PC register and the decode stage. Each cycle it captures the current PC and the instruction word read combinationally from instruction memory at that PC, and queues them in a small FIFO. It presents the queue head to decode with a valid/ready handshake and drives the PC register's enable so the PC advances only when a fetch is accepted. A flush input from branch/jump resolution empties the queue and lets the PC register load the redirect target.

---
 rtl/if_fetch_queue.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch buffer that sits between the PC register and decode. Each
// cycle it captures the PC and the instruction word that instruction memory
// returns combinationally for that PC. It queues the pair in a small FIFO,
// presents the oldest entry to decode through a valid/ready handshake, and
// drives the PC register's enable so the PC only advances when a fetch is
// accepted. A flush from branch/jump resolution empties the queue. In the same
// cycle the PC register loads the redirect target.
//
// Parameters
//   DEPTH     number of queue entries (power of two, >= 2)
//   PC_BASE   lowest legal instruction address
//   PC_LIMIT  highest legal instruction address (inclusive)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low; clears all state
//   F_pc        current PC from the PC register
//   F_instr     instruction word at F_pc (combinational IM read)
//   F_pc_en     PC register enable; 1 = PC loads its next value this edge
//   flush       redirect; discards queued entries and the current fetch
//   D_ready     decode accepts the head entry this cycle
//   D_valid     head entry present
//   D_pc        PC of the head entry
//   D_pc8       head PC + 8 (link value), wraps modulo 2^32
//   D_instr     instruction of the head entry, 0 when the fetch faulted
//   D_exc_adel  head entry address misaligned or out of range
//   count       number of valid entries
// -----------------------------------------------------------------------------
module if_fetch_queue #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] PC_BASE  = 32'h0000_3000,
   parameter logic [31:0] PC_LIMIT = 32'h0000_6ffc
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              F_pc,
   input  logic [31:0]              F_instr,
   output logic                     F_pc_en,
   input  logic                     flush,
   input  logic                     D_ready,
   output logic                     D_valid,
   output logic [31:0]              D_pc,
   output logic [31:0]              D_pc8,
   output logic [31:0]              D_instr,
   output logic                     D_exc_adel,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("if_fetch_queue: DEPTH must be a power of two and at least 2");
   end

   // Misaligned or outside the legal instruction window.
   function automatic logic fetch_fault(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < PC_BASE) || (pc > PC_LIMIT);
   endfunction

   // Entry storage
   logic [31:0]   pc_q    [DEPTH];
   logic [31:0]   instr_q [DEPTH];
   logic          exc_q   [DEPTH];

   // Control state
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic          full;
   logic          empty;
   logic          pop;
   logic          push;
   logic          fault;
   logic [31:0]   wr_instr;

   always_comb begin
      full     = (count_q == CW'(DEPTH));
      empty    = (count_q == '0);
      // Decode must not consume the head on a flush cycle, so flush masks pop.
      pop      = ~empty & D_ready & ~flush;
      // Pushing into a full queue is fine when the head leaves in the same cycle.
      push     = ~flush & (~full | pop);
      // Reset holds the PC register; otherwise it advances on an accepted
      // fetch or loads the redirect target on flush.
      F_pc_en  = reset & (push | flush);

      fault    = fetch_fault(F_pc);
      wr_instr = fault ? 32'h0000_0000 : F_instr;

      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers are log2(DEPTH) bits wide, so the increment wraps modulo DEPTH.
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is only cleared on reset. A flush leaves stale data behind, but
   // the empty-gating on the outputs hides it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
            exc_q[i]   <= 1'b0;
         end
      end else if (push) begin
         pc_q[wr_ptr_q]    <= F_pc;
         instr_q[wr_ptr_q] <= wr_instr;
         exc_q[wr_ptr_q]   <= fault;
      end
   end

   // Outputs come only from registered state, so there is no path from
   // F_pc/F_instr to decode.
   always_comb begin
      D_valid    = ~empty;
      D_pc       = 32'h0000_0000;
      D_pc8      = 32'h0000_0000;
      D_instr    = 32'h0000_0000;
      D_exc_adel = 1'b0;
      if (!empty) begin
         D_pc       = pc_q[rd_ptr_q];
         D_pc8      = pc_q[rd_ptr_q] + 32'd8;
         D_instr    = instr_q[rd_ptr_q];
         D_exc_adel = exc_q[rd_ptr_q];
      end
   end

   assign count = count_q;

endmodule
